// File: rtl/confreg_pkg.sv
// Shared constants and helpers for the data-SRAM responder and its MMIO register file.
package confreg_pkg;

  localparam logic [15:0] LED_OFF    = 16'h0000;
  localparam logic [15:0] SW_OFF     = 16'h0004;
  localparam logic [15:0] TIMER_OFF  = 16'h0008;
  localparam logic [15:0] CMP_OFF    = 16'h000C;
  localparam logic [15:0] STATUS_OFF = 16'h0010;

  localparam logic [31:0] CMP_RESET  = 32'hFFFF_FFFF;

  // Replace each byte of oldWord whose enable is set with the matching byte of newWord.
  function automatic logic [31:0] byte_merge(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = newWord[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/byte_we_sram.sv
// Byte-writable single-port RAM, read-first with a registered read port.
module byte_we_sram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [2**AW];

  // The old word is captured before the byte lanes are updated, so a write cycle returns pre-write data.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= r_mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_confreg_resp.sv
// Data-SRAM responder: splits core accesses between on-chip RAM and a small MMIO register file
// (LEDs, synchronized switches, timer with compare interrupt, status).
module dmem_confreg_resp
  import confreg_pkg::*;
#(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_i,
  output logic [15:0] led_o,
  output logic        timer_int_o
);

  logic        w_acc, w_mmio, w_ramEn, w_wr;
  logic [15:0] w_off;
  logic        w_timerWr, w_cmpWr, w_ledWr, w_statusClr, w_pendSet;
  logic [31:0] w_timerNext, w_mmioRd, w_ramRdata;

  logic [31:0] r_timer, r_compare, r_mmioRdata;
  logic [15:0] r_led;
  logic [7:0]  r_swMeta, r_swSync;
  logic        r_pending, r_isMmio, r_rdValid;

  // Accesses presented during reset are dropped entirely, including the RAM write.
  assign w_acc   = data_sram_en & ~rst;
  assign w_mmio  = (data_sram_addr[31:16] == MMIO_HI);
  assign w_off   = data_sram_addr[15:0] & 16'hFFFC;
  assign w_ramEn = w_acc & ~w_mmio;
  assign w_wr    = w_acc & w_mmio & (data_sram_wen != 4'b0000);

  assign w_timerWr   = w_wr && (w_off == TIMER_OFF);
  assign w_cmpWr     = w_wr && (w_off == CMP_OFF);
  assign w_ledWr     = w_wr && (w_off == LED_OFF);
  assign w_statusClr = w_wr && (w_off == STATUS_OFF) && data_sram_wen[0] && data_sram_wdata[0];

  assign w_timerNext = w_timerWr ? byte_merge(r_timer, data_sram_wdata, data_sram_wen)
                                 : r_timer + 32'd1;
  assign w_pendSet   = !w_timerWr && !w_cmpWr && (w_timerNext == r_compare);

  always_comb begin
    w_mmioRd = 32'h0;
    case (w_off)
      LED_OFF:    w_mmioRd = {16'h0, r_led};
      SW_OFF:     w_mmioRd = {24'h0, r_swSync};
      TIMER_OFF:  w_mmioRd = r_timer;
      CMP_OFF:    w_mmioRd = r_compare;
      STATUS_OFF: w_mmioRd = {31'h0, r_pending};
      default:    w_mmioRd = 32'h0;
    endcase
  end

  byte_we_sram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (w_ramEn),
    .wen   (data_sram_wen),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (w_ramRdata)
  );

  // A set in the same cycle as a clear wins, so an interrupt edge is never lost to a W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= 32'h0;
      r_compare   <= CMP_RESET;
      r_pending   <= 1'b0;
      r_led       <= 16'h0;
      r_swMeta    <= 8'h0;
      r_swSync    <= 8'h0;
      r_mmioRdata <= 32'h0;
      r_isMmio    <= 1'b0;
      r_rdValid   <= 1'b0;
    end else begin
      r_timer  <= w_timerNext;
      r_swMeta <= switch_i;
      r_swSync <= r_swMeta;
      if (w_cmpWr) r_compare <= byte_merge(r_compare, data_sram_wdata, data_sram_wen);
      if (w_pendSet) r_pending <= 1'b1;
      else if (w_statusClr || w_cmpWr) r_pending <= 1'b0;
      if (w_ledWr && data_sram_wen[0]) r_led[7:0]  <= data_sram_wdata[7:0];
      if (w_ledWr && data_sram_wen[1]) r_led[15:8] <= data_sram_wdata[15:8];
      if (w_acc) begin
        r_isMmio  <= w_mmio;
        r_rdValid <= 1'b1;
      end
      if (w_acc && w_mmio) r_mmioRdata <= w_mmioRd;
    end
  end

  // Both sources hold between accesses, so rdata keeps its last value while en is low.
  assign data_sram_rdata = !r_rdValid ? 32'h0 : (r_isMmio ? r_mmioRdata : w_ramRdata);
  assign led_o       = r_led;
  assign timer_int_o = r_pending;

endmodule

// File: tb/tb_dmem_confreg_resp.sv
// Directed test of dmem_confreg_resp: RAM byte writes and aliasing, MMIO registers, timer interrupt, reset.
module tb_dmem_confreg_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_i = 8'h00;
  logic [15:0] led_o;
  logic        timer_int_o;

  int numChecks = 0;
  int numFails  = 0;

  localparam logic [31:0] LED_A = 32'hBFAF_0000;
  localparam logic [31:0] SW_A  = 32'hBFAF_0004;
  localparam logic [31:0] TMR_A = 32'hBFAF_0008;
  localparam logic [31:0] CMP_A = 32'hBFAF_000C;
  localparam logic [31:0] STS_A = 32'hBFAF_0010;

  dmem_confreg_resp dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_i        (switch_i),
    .led_o           (led_o),
    .timer_int_o     (timer_int_o)
  );

  always #5 clk = ~clk;

  // On return, outputs reflect the operation driven on the previous call.
  task automatic applyStimulus(input logic en, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset rdata", data_sram_rdata, 32'h0);
    checkOutput("reset led", {16'h0, led_o}, 32'h0);
    checkOutput("reset int", {31'h0, timer_int_o}, 32'h0);
    rst = 1'b0;
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = TMR_A;
    applyStimulus(1'b1, 4'h0, CMP_A, 32'h0);
    checkOutput("timer after reset", data_sram_rdata, 32'h0);
    idleCycle();
    checkOutput("compare reset", data_sram_rdata, 32'hFFFF_FFFF);

    // RAM byte write with read-first on the partial write
    applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344);
    applyStimulus(1'b1, 4'h2, 32'h0000_0100, 32'hAAAA_AAAA);
    applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checkOutput("ram read-first bytewr", data_sram_rdata, 32'h1122_3344);
    idleCycle();
    checkOutput("ram byte merge", data_sram_rdata, 32'h1122_AA44);
    idleCycle();
    checkOutput("rdata hold", data_sram_rdata, 32'h1122_AA44);

    // Aliasing: 0x0001_0000 wraps onto word 0
    applyStimulus(1'b1, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 4'hF, 32'h0001_0000, 32'h1234_5678);
    applyStimulus(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    checkOutput("alias read-first", data_sram_rdata, 32'hDEAD_BEEF);
    idleCycle();
    checkOutput("alias wrap", data_sram_rdata, 32'h1234_5678);

    // LED, SWITCH, unmapped
    applyStimulus(1'b1, 4'hF, LED_A, 32'hFFFF_1234);
    applyStimulus(1'b1, 4'h0, LED_A, 32'h0);
    checkOutput("led_o", {16'h0, led_o}, 32'h0000_1234);
    switch_i = 8'h5A;
    idleCycle();
    checkOutput("led read", data_sram_rdata, 32'h0000_1234);
    idleCycle();
    applyStimulus(1'b1, 4'h0, SW_A, 32'h0);
    idleCycle();
    checkOutput("switch read", data_sram_rdata, 32'h0000_005A);
    applyStimulus(1'b1, 4'hF, 32'hBFAF_0020, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 4'h0, 32'hBFAF_0020, 32'h0);
    idleCycle();
    checkOutput("unmapped read", data_sram_rdata, 32'h0);

    // Timer/compare: interrupt rises 4 cycles after the TIMER write cycle
    applyStimulus(1'b1, 4'hF, TMR_A, 32'h0000_0010);
    applyStimulus(1'b1, 4'hF, CMP_A, 32'h0000_0014);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("int before match", {31'h0, timer_int_o}, 32'h0);
    idleCycle();
    checkOutput("int at match", {31'h0, timer_int_o}, 32'h1);
    applyStimulus(1'b1, 4'h1, STS_A, 32'h0000_0001);
    checkOutput("int held", {31'h0, timer_int_o}, 32'h1);
    idleCycle();
    checkOutput("int w1c", {31'h0, timer_int_o}, 32'h0);
    applyStimulus(1'b1, 4'h0, TMR_A, 32'h0);
    idleCycle();
    checkOutput("timer count", data_sram_rdata, 32'h0000_0017);

    // COMPARE write clears pending
    applyStimulus(1'b1, 4'hF, TMR_A, 32'h0000_0020);
    applyStimulus(1'b1, 4'hF, CMP_A, 32'h0000_0022);
    idleCycle();
    idleCycle();
    checkOutput("int second match", {31'h0, timer_int_o}, 32'h1);
    applyStimulus(1'b1, 4'hF, CMP_A, 32'hFFFF_0000);
    idleCycle();
    checkOutput("int cmp clear", {31'h0, timer_int_o}, 32'h0);

    // Set/clear collision: W1C in the same cycle the match fires
    applyStimulus(1'b1, 4'hF, TMR_A, 32'h0000_0040);
    applyStimulus(1'b1, 4'hF, CMP_A, 32'h0000_0042);
    idleCycle();
    applyStimulus(1'b1, 4'hF, TMR_A, 32'h0000_0040);
    checkOutput("int pre-collision", {31'h0, timer_int_o}, 32'h1);
    idleCycle();
    applyStimulus(1'b1, 4'h1, STS_A, 32'h0000_0001);
    applyStimulus(1'b1, 4'h0, STS_A, 32'h0);
    checkOutput("collision set wins", {31'h0, timer_int_o}, 32'h1);
    applyStimulus(1'b1, 4'h1, STS_A, 32'h0000_0001);
    checkOutput("status read", data_sram_rdata, 32'h0000_0001);
    idleCycle();
    checkOutput("int final clear", {31'h0, timer_int_o}, 32'h0);

    // Reset during an LED write
    @(negedge clk);
    rst = 1'b1;
    data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = LED_A; data_sram_wdata = 32'h0000_ABCD;
    @(negedge clk);
    checkOutput("rst led", {16'h0, led_o}, 32'h0);
    checkOutput("rst rdata", data_sram_rdata, 32'h0);
    rst = 1'b0;
    data_sram_wen = 4'h0; data_sram_addr = TMR_A;
    applyStimulus(1'b1, 4'h0, TMR_A, 32'h0);
    checkOutput("timer restart", data_sram_rdata, 32'h0);
    idleCycle();
    checkOutput("timer restart+1", data_sram_rdata, 32'h1);
    checkOutput("led after rst", {16'h0, led_o}, 32'h0);

    // Reset during a RAM write: stored word must survive
    @(negedge clk);
    rst = 1'b1;
    data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = 32'h0000_0100; data_sram_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b0;
    data_sram_wen = 4'h0;
    idleCycle();
    checkOutput("ram write in reset dropped", data_sram_rdata, 32'h1122_AA44);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/dmem_confreg_resp.md
# dmem_confreg_resp

Responder for the core's data-SRAM interface: accepts `data_sram_en/wen/addr/wdata` from the execute stage and returns `data_sram_rdata` one cycle later. Word addresses in the MMIO window decode to a small register file: LEDs, synchronized switches, a free-running timer with compare interrupt, and status. All other addresses go to on-chip byte-writable RAM. The block sits at the top level beside the core and replaces the external data RAM plus board config-register glue.

## Interface
Parameters:
- RAM_AW, 14, RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- data_sram_en  in  1  access request this cycle.
- data_sram_wen  in  4  byte write enables; 0 means read.
- data_sram_addr  in  32  byte address (low 2 bits ignored).
- data_sram_wdata  in  32  write data, already byte-replicated by the core.
- data_sram_rdata  out  32  read data, registered.
- switch_i  in  8  asynchronous board switches.
- led_o  out  16  LED register.
- timer_int_o  out  1  level interrupt, equals STATUS.pending.

## Operation
- Region select: `mmio = (addr[31:16] == MMIO_HI)`. Otherwise RAM.
- RAM index: addr[RAM_AW+1:2]. Upper bits are ignored, so out-of-range addresses alias (wrap).
- RAM write: when en and wen≠0, update byte i iff wen[i].
- RAM read: read-first. rdata gets the pre-write contents of the addressed word, including on a write cycle.
- MMIO offsets (addr[15:0]):
  - 0x0000 LED: RW, bits 15:0. Bytes 0–1 are writable; higher bytes are ignored and read 0.
  - 0x0004 SWITCH: RO, {24'b0, sw_sync}, where sw_sync is a 2-FF synchronizer of switch_i.
  - 0x0008 TIMER: RW, all four bytes. Increments by 1 every cycle and wraps 0xFFFFFFFF→0.
  - 0x000C COMPARE: RW, all four bytes.
  - 0x0010 STATUS: bit0 = pending. Writing 1 to bit0 (wen[0]) clears it; bits 31:1 read 0.
  - Any other offset reads 0; writes to it are ignored.
- MMIO reads are registered. rdata shows the value before any same-cycle write; this matches RAM read-first.
- Timer:
  - A TIMER write loads the byte-merged value, and the timer does not increment that cycle.
  - Otherwise timer_next = timer + 1.
- Interrupt:
  - pending is set when timer_next == compare (timer updated, compare not written this cycle).
  - pending is cleared by STATUS W1C or by any COMPARE write.
  - If set and clear occur in the same cycle, set wins.
- en=0: no state change except timer/pending/sync. rdata holds its last value.

## Timing
- Read latency is 1: the request in cycle N gives rdata valid in cycle N+1. There are no wait states, and back-to-back accesses are allowed every cycle.
- Write takes effect at the end of the request cycle. A read of the same address in N+1 returns the new data in N+2.
- Switch input to SWITCH readback: 2 cycles of synchronizer latency plus 1 read cycle.
- Reset values:
  - rdata 0, led_o 0, timer 0, compare 0xFFFFFFFF, pending 0 (timer_int_o 0), sync FFs 0.
  - RAM contents are not reset.
- Reset asserted mid-operation:
  - An access presented in the reset cycle is dropped, including MMIO writes.
  - A RAM write in the reset cycle is also suppressed.
  - rdata reads 0 the cycle after reset.

## Structure
- Shared package `confreg_pkg`: offset constants (LED_OFF, SW_OFF, TIMER_OFF, CMP_OFF, STATUS_OFF), the reset value of COMPARE, and the byte-merge function (old, new, wen)→word.
- Sub-module `byte_we_sram`:
  - Parameters: AW.
  - Ports: clk, en, wen[3:0], addr, wdata, rdata.
  - Behaviour: read-first, registered output.
- The top level holds the MMIO registers, the synchronizer, region decode and the rdata mux. The mux selects using the registered region and offset from cycle N.

## Test plan
- RAM byte write: write 0x11223344 to 0x0000_0100 (wen=F), then wen=4'b0010 with wdata 0xAAAAAAAA, then read → rdata 0x1122AA44 one cycle after the read request.
- Read-first and aliasing: with RAM_AW=14, write 0xDEADBEEF to 0x0000_0000, then access 0x0001_0000 → read-first data on the write cycle, then 0xDEADBEEF; confirms the wrap.
- Timer and interrupt:
  - Write TIMER=0x10 and COMPARE=0x14 → timer_int_o rises exactly 4 cycles after the TIMER write cycle ends.
  - Write STATUS=1 → timer_int_o falls next cycle.
  - Writing COMPARE also clears pending.
- Set/clear collision: arrange timer_next==compare in the same cycle as a STATUS W1C → pending stays 1.
- LED/SWITCH: write LED 0xFFFF_1234 (wen=F) → led_o=0x1234 and LED read=0x00001234. Drive switch_i=0x5A → SWITCH read 0x0000005A once 3 cycles have elapsed. Unmapped 0xBFAF_0020 → read 0.
- Reset mid-write: assert rst together with en/wen=F to LED → led_o stays 0 and rdata=0 after reset; timer restarts from 0.
